// File: rtl/present_engine_if.sv
// -----------------------------------------------------------------------------
// present_engine_if
//   Handshake bundle between a PRESENT engine and its block source/result sink.
//   master : drives plaintext/key offers, abort and result acceptance
//   slave  : the engine; reports readiness, result and activity
// Signals
//   clear      synchronous abort of the in-flight block
//   in_valid   plaintext/key offered        in_ready   engine accepts this cycle
//   plaintext  64-bit block                 key        KEY_SIZE-bit cipher key
//   out_valid  ciphertext valid             out_ready  consumer takes ciphertext
//   ciphertext 64-bit result (0 when idle)  busy       engine in RUN or DONE
// -----------------------------------------------------------------------------
interface present_engine_if #(
    parameter int KEY_SIZE = 128
);
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [63:0]         plaintext;
    logic [KEY_SIZE-1:0] key;
    logic                out_valid;
    logic                out_ready;
    logic [63:0]         ciphertext;
    logic                busy;

    modport master (
        output clear, in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  clear, in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );
endinterface

// File: rtl/present_engine.sv
// -----------------------------------------------------------------------------
// present_engine
//   Iterative PRESENT-80/128 encryption engine with RPC rounds per clock.
//   A block is accepted on in_valid & in_ready, run for ceil(31/RPC) cycles,
//   then held in DONE (out_valid=1) until out_ready. A new block may be
//   accepted in the same cycle a result is taken (back-to-back).
// Ports
//   clk    rising-edge clock
//   nrst   asynchronous active-low reset
//   bus    present_engine_if.slave (handshakes, data, clear, busy)
// -----------------------------------------------------------------------------
module present_engine #(
    parameter int KEY_SIZE = 128,
    parameter int RPC      = 1
) (
    input  logic              clk,
    input  logic              nrst,
    present_engine_if.slave   bus
);

    if (!(KEY_SIZE == 80 || KEY_SIZE == 128)) begin : g_bad_key_size
        $error("present_engine: KEY_SIZE must be 80 or 128");
    end
    if (RPC < 1 || RPC > 31) begin : g_bad_rpc
        $error("present_engine: RPC must be in 1..31");
    end

    // Bit position of the 5-bit round-counter salt in the updated key.
    localparam int SALT_LO = (KEY_SIZE == 128) ? 62 : 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_data;
    logic [KEY_SIZE-1:0] r_key;
    // Six bits: the counter runs up to 31+RPC on the last compute cycle.
    logic [5:0]          r_rnd;

    logic [63:0]         w_data_nxt;
    logic [KEY_SIZE-1:0] w_key_nxt;
    logic                w_last;
    logic                w_in_ready;
    logic                w_accept;

    // ---------------------------------------------------------------- cipher
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    // Add round key, S-box layer, then bit i -> 16*i mod 63 (bit 63 fixed).
    function automatic logic [63:0] round_data(input logic [63:0] d,
                                               input logic [KEY_SIZE-1:0] k);
        logic [63:0] s;
        logic [63:0] p;
        s = d ^ k[KEY_SIZE-1 -: 64];
        for (int i = 0; i < 16; i++) begin
            s[4*i +: 4] = sbox(s[4*i +: 4]);
        end
        p = '0;
        for (int i = 0; i < 63; i++) begin
            p[(16 * i) % 63] = s[i];
        end
        p[63] = s[63];
        return p;
    endfunction

    function automatic logic [KEY_SIZE-1:0] key_update(input logic [KEY_SIZE-1:0] k,
                                                       input logic [4:0] r);
        logic [KEY_SIZE-1:0] t;
        t = (k << 61) | (k >> (KEY_SIZE - 61));
        t[KEY_SIZE-1 -: 4] = sbox(t[KEY_SIZE-1 -: 4]);
        if (KEY_SIZE == 128) begin
            t[KEY_SIZE-5 -: 4] = sbox(t[KEY_SIZE-5 -: 4]);
        end
        t[SALT_LO +: 5] = t[SALT_LO +: 5] ^ r;
        return t;
    endfunction

    // RPC chained rounds; indices past 31 pass data and key through untouched.
    always_comb begin : p_rounds
        logic [6:0] idx;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_data_nxt = r_data;
        w_key_nxt  = r_key;
        idx        = '0;
        for (int i = 0; i < RPC; i++) begin
            idx = {1'b0, r_rnd} + 7'(i);
            if (idx <= 7'd31) begin
                w_data_nxt = round_data(w_data_nxt, w_key_nxt);
                w_key_nxt  = key_update(w_key_nxt, idx[4:0]);
            end
        end
    end

    // This cycle's range rnd..rnd+RPC-1 reaches round 31.
    assign w_last = (({1'b0, r_rnd} + 7'(RPC) - 7'd1) >= 7'd31);

    // ------------------------------------------------------------ handshake
    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
    // clear wins over a same-cycle accept: nothing is loaded.
    assign w_accept   = bus.in_valid && w_in_ready && !bus.clear;

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept)           w_state_nxt = S_RUN;
                else if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_key   <= '0;
            r_rnd   <= 6'd1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= bus.plaintext;
                r_key  <= bus.key;
                r_rnd  <= 6'd1;
            end else if (r_state == S_RUN && !bus.clear) begin
                r_data <= w_data_nxt;
                r_key  <= w_key_nxt;
                r_rnd  <= r_rnd + 6'(RPC);
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_DONE);
    // Final add-round-key with K32; forced to zero outside DONE.
    assign bus.ciphertext = (r_state == S_DONE) ? (r_data ^ r_key[KEY_SIZE-1 -: 64]) : 64'h0;
    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DONE);

endmodule
